// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU: operation classes, funct3 codes
// and the default datapath width.
// Imported by alu, alu_shifter and the testbench.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  // Operation class carried on ALUOp
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHIFT = 3'b101,
    ALU_CMP   = 3'b110,
    ALU_OP7   = 3'b111
  } alu_op_e;

  // Sub-operation codes in funct3[2:0]
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read stage and the ALU.
// master drives operands and opcode, slave (the ALU) returns result and zero.
// No handshake: a new operation is presented every cycle.
interface alu_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] operandB;
  logic [2:0]        ALUOp;
  logic [5:0]        funct3;
  logic              zero;
  logic [DATA_W-1:0] result;

  modport master (
    output operandA, operandB, ALUOp, funct3,
    input  zero, result
  );

  modport slave (
    input  operandA, operandB, ALUOp, funct3,
    output zero, result
  );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: SLL / SRL / SRA of a by a 5-bit amount.
// Zero latency; unknown funct3 codes produce 0.
// No flow control.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [4:0]        shamt,
  input  logic [2:0]        f3,
  input  logic              arith,
  output logic [DATA_W-1:0] res
);

  // Select shift direction/kind; arith only matters for right shifts
  always_comb begin
    res = '0;
    if (f3 == F3_SLL) begin
      res = a << shamt;
    end else if (f3 == F3_SRX) begin
      if (arith) res = DATA_W'($signed(a) >>> shamt);
      else       res = a >> shamt;
    end
  end

endmodule

// File: rtl/alu.sv
// Integer ALU: ADD/SUB/AND/OR/XOR/shift/compare plus ALUOp 111 (MUL when
// ALU_MUL_EN is defined, otherwise pass operandB). One-cycle registered
// result and zero flag; accepts an operation every cycle, no backpressure.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clock,
  input logic reset,
  alu_if.slave bus
);

  alu_op_e           op;
  logic [2:0]        f3_lo;
  logic [DATA_W-1:0] shift_res;
  logic [DATA_W-1:0] next_result;
  logic              unused_f3;

  assign op    = alu_op_e'(bus.ALUOp);
  assign f3_lo = bus.funct3[2:0];

  // funct3[4:3] carry no meaning for this ALU
  assign unused_f3 = &{1'b0, bus.funct3[4:3]};

  alu_shifter #(.DATA_W(DATA_W)) u_shifter (
    .a     (bus.operandA),
    .shamt (bus.operandB[4:0]),
    .f3    (f3_lo),
    .arith (bus.funct3[5]),
    .res   (shift_res)
  );

  // Next-result mux; compare results are zero-extended single bits
  always_comb begin
    next_result = '0;
    unique case (op)
      ALU_ADD:   next_result = bus.operandA + bus.operandB;
      ALU_SUB:   next_result = bus.operandA - bus.operandB;
      ALU_AND:   next_result = bus.operandA & bus.operandB;
      ALU_OR:    next_result = bus.operandA | bus.operandB;
      ALU_XOR:   next_result = bus.operandA ^ bus.operandB;
      ALU_SHIFT: next_result = shift_res;
      ALU_CMP: begin
        if (f3_lo == F3_SLT)
          next_result = {{(DATA_W-1){1'b0}},
                         ($signed(bus.operandA) < $signed(bus.operandB))};
        else if (f3_lo == F3_SLTU)
          next_result = {{(DATA_W-1){1'b0}}, (bus.operandA < bus.operandB)};
      end
`ifdef ALU_MUL_EN
      ALU_OP7:   next_result = bus.operandA * bus.operandB;
`else
      ALU_OP7:   next_result = bus.operandB;
`endif
      default:   next_result = '0;
    endcase
  end

  // Output register; zero is derived from the value being loaded
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.result <= '0;
      bus.zero   <= 1'b1;
    end else begin
      bus.result <= next_result;
      bus.zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu with an expected-value queue: the driver
// pushes hand-computed results, a monitor pops and compares one cycle later.
// Also covers async reset assertion mid-run and reset release behaviour.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    string       name;
  } exp_t;

  logic clock;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  exp_t exp_q[$];

  alu_if #(.DATA_W(32)) bus ();

  alu #(.DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Apply a vector right now and record what the next edge must load
  task automatic drive(input alu_op_e op, input logic [5:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input string name);
    exp_t e;
    bus.ALUOp    = op;
    bus.funct3   = f3;
    bus.operandA = a;
    bus.operandB = b;
    e.res  = res;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic issue(input alu_op_e op, input logic [5:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input string name);
    @(negedge clock);
    drive(op, f3, a, b, res, name);
  endtask

  // Monitor: one result per edge for every issued vector
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".result"}, bus.result, e.res);
        check({e.name, ".zero"}, {31'd0, bus.zero}, {31'd0, (e.res == 32'd0)});
      end
    end
  end

  initial begin
    int waited;
    reset        = 1'b1;
    bus.ALUOp    = ALU_ADD;
    bus.funct3   = 6'd0;
    bus.operandA = 32'd7;
    bus.operandB = 32'd9;
    #2;
    check("reset.result", bus.result, 32'd0);
    check("reset.zero", {31'd0, bus.zero}, 32'd1);

    @(negedge clock);
    reset = 1'b0;

    issue(ALU_ADD, 6'b000000, 32'h0A, 32'h05, 32'h0F, "add");
    issue(ALU_SUB, 6'b111111, 32'h0A, 32'h05, 32'h05, "sub");
    issue(ALU_AND, 6'b000000, 32'h0A, 32'h05, 32'h00, "and");
    issue(ALU_XOR, 6'b000000, 32'h0A, 32'h05, 32'h0F, "xor");
    issue(ALU_ADD, 6'b000000, 32'hFFFF_FFFF, 32'h1, 32'h0, "add_wrap");
    issue(ALU_SUB, 6'b000000, 32'h0, 32'h1, 32'hFFFF_FFFF, "sub_wrap");
    issue(ALU_SHIFT, 6'b000101, 32'h8000_0000, 32'h4, 32'h0800_0000, "srl");
    issue(ALU_SHIFT, 6'b100101, 32'h8000_0000, 32'h4, 32'hF800_0000, "sra");
    issue(ALU_SHIFT, 6'b000101, 32'h0000_00F0, 32'hFFFF_FFE4, 32'h0000_000F, "srl_hi_b");
    issue(ALU_SHIFT, 6'b000001, 32'h1, 32'h24, 32'h10, "sll");
    issue(ALU_SHIFT, 6'b000001, 32'h1234, 32'h20, 32'h1234, "sll_shamt0");
    issue(ALU_SHIFT, 6'b100000, 32'hFFFF, 32'h1, 32'h0, "shift_bad_f3");
    issue(ALU_CMP, 6'b000010, 32'h8000_0000, 32'h1, 32'h1, "slt");
    issue(ALU_CMP, 6'b000011, 32'h8000_0000, 32'h1, 32'h0, "sltu");
    issue(ALU_CMP, 6'b011010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, "slt_extreme");
    issue(ALU_CMP, 6'b000011, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, "sltu_extreme");
    issue(ALU_CMP, 6'b000011, 32'h5, 32'h8000_0000, 32'h1, "sltu_lt");
    issue(ALU_CMP, 6'b000000, 32'h0, 32'h1, 32'h0, "cmp_bad_f3");
`ifdef ALU_MUL_EN
    issue(ALU_OP7, 6'b000000, 32'h3, 32'h5, 32'hF, "op7_mul");
    issue(ALU_OP7, 6'b000000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, "op7_mul_neg");
`else
    issue(ALU_OP7, 6'b000000, 32'h3, 32'h5, 32'h5, "op7_pass");
    issue(ALU_OP7, 6'b000000, 32'h3, 32'h0, 32'h0, "op7_pass_zero");
`endif
    issue(ALU_OR, 6'b000000, 32'h0A, 32'h05, 32'h0F, "or");

    // Async reset between edges while result holds 0x0F
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midreset.result", bus.result, 32'd0);
    check("midreset.zero", {31'd0, bus.zero}, 32'd1);
    bus.ALUOp    = ALU_ADD;
    bus.operandA = 32'h1;
    bus.operandB = 32'h1;
    @(posedge clock);
    #1;
    check("reset_held.result", bus.result, 32'd0);
    check("reset_held.zero", {31'd0, bus.zero}, 32'd1);

    // Release: the very next edge must load a fresh result
    @(negedge clock);
    reset = 1'b0;
    drive(ALU_ADD, 6'b000000, 32'h20, 32'h01, 32'h21, "post_reset");
    issue(ALU_SUB, 6'b000000, 32'h21, 32'h21, 32'h0, "sub_zero");

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
